pong_match_ctrl: RTL

//  Match sequencer for the pong datapath. Sits between pong_graph (pts_1/pts_2), the frame tick,
//  the buttons and the two m100_counter score units. Owns ball budget, serve/game-over delays,
//  win detection and winner reporting. Replaces the ad-hoc FSM and standalone timer in the top level.

---
 rtl/pong_match_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: ball budget, serve/game-over delays, win detection and score-counter control.
// Optional macro PONG_MATCH_DEUCE_EN: a match at WIN_SCORE continues until one side leads by 2.
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int BALLS        = 7,
  parameter int SERVE_FRAMES = 120,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_frame_tick,
  input  logic [3:0] i_btn,
  input  logic       i_pts_1,
  input  logic       i_pts_2,
  output logic       o_gra_still,
  output logic       o_d1_inc,
  output logic       o_d1_clr,
  output logic       o_d2_inc,
  output logic       o_d2_clr,
  output logic [6:0] o_ball,
  output logic [1:0] o_state,
  output logic       o_serve_side,
  output logic [1:0] o_winner
);

  // states: NEWGAME idle/cleared, PLAY ball live, NEWBALL serve hold, OVER result shown
  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam logic [6:0] BALLS_V = 7'(BALLS);
  localparam logic [6:0] WIN_V   = 7'(WIN_SCORE);
  localparam logic [7:0] SERVE_V = 8'(SERVE_FRAMES);
  localparam logic [7:0] OVER_V  = 8'(OVER_FRAMES);
`ifdef PONG_MATCH_DEUCE_EN
  localparam logic [6:0] SCORE_MAX = 7'd99;
`else
  localparam logic [6:0] SCORE_MAX = 7'(WIN_SCORE);
`endif

  state_t     r_state;
  logic       r_gra_still, r_d1_inc, r_d1_clr, r_d2_inc, r_d2_clr;
  logic       r_serve_side, r_btn_any;
  logic [6:0] r_ball, r_s1, r_s2;
  logic [7:0] r_timer;
  logic [1:0] r_winner;

  logic       w_press, w_p1, w_p2, w_win, w_end;
  logic [6:0] w_s1_nxt, w_s2_nxt, w_ball_nxt;
  logic [1:0] w_winner_nxt;

  assign w_press = (|i_btn) & ~r_btn_any;
  assign w_p1    = i_pts_1;
  assign w_p2    = i_pts_2 & ~i_pts_1;

  always_comb begin
    w_s1_nxt   = r_s1;
    w_s2_nxt   = r_s2;
    w_ball_nxt = r_ball;
    if (w_p1 && (r_s1 != SCORE_MAX)) w_s1_nxt = r_s1 + 7'd1;
    if (w_p2 && (r_s2 != SCORE_MAX)) w_s2_nxt = r_s2 + 7'd1;
    if ((w_p1 || w_p2) && (r_ball != 7'd0)) w_ball_nxt = r_ball - 7'd1;
`ifdef PONG_MATCH_DEUCE_EN
    w_win = ((w_s1_nxt >= WIN_V) && ({1'b0, w_s1_nxt} >= ({1'b0, w_s2_nxt} + 8'd2))) ||
            ((w_s2_nxt >= WIN_V) && ({1'b0, w_s2_nxt} >= ({1'b0, w_s1_nxt} + 8'd2)));
`else
    w_win = (w_s1_nxt == WIN_V) || (w_s2_nxt == WIN_V);
`endif
    w_end = w_win || (w_ball_nxt == 7'd0);
    if (w_s1_nxt > w_s2_nxt)      w_winner_nxt = 2'b01;
    else if (w_s2_nxt > w_s1_nxt) w_winner_nxt = 2'b10;
    else                          w_winner_nxt = 2'b11;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= ST_NEWGAME;
      r_gra_still  <= 1'b1;
      r_d1_inc     <= 1'b0;
      r_d2_inc     <= 1'b0;
      r_d1_clr     <= 1'b1;
      r_d2_clr     <= 1'b1;
      r_ball       <= BALLS_V;
      r_serve_side <= 1'b0;
      r_winner     <= 2'b00;
      r_timer      <= 8'd0;
      r_s1         <= 7'd0;
      r_s2         <= 7'd0;
      r_btn_any    <= 1'b0;
    end else begin
      r_btn_any <= |i_btn;
      r_d1_inc  <= 1'b0;
      r_d2_inc  <= 1'b0;
      case (r_state)
        ST_NEWGAME: begin
          r_gra_still <= 1'b1;
          r_d1_clr    <= 1'b1;
          r_d2_clr    <= 1'b1;
          r_ball      <= BALLS_V;
          r_s1        <= 7'd0;
          r_s2        <= 7'd0;
          r_winner    <= 2'b00;
          if (w_press) begin
            r_state     <= ST_PLAY;
            r_gra_still <= 1'b0;
            r_d1_clr    <= 1'b0;
            r_d2_clr    <= 1'b0;
          end
        end
        ST_PLAY: begin
          r_gra_still <= 1'b0;
          if (w_p1 || w_p2) begin
            r_d1_inc     <= w_p1;
            r_d2_inc     <= w_p2;
            r_s1         <= w_s1_nxt;
            r_s2         <= w_s2_nxt;
            r_ball       <= w_ball_nxt;
            r_serve_side <= w_p1;
            r_gra_still  <= 1'b1;
            if (w_end) begin
              r_state  <= ST_OVER;
              r_timer  <= OVER_V;
              r_winner <= w_winner_nxt;
            end else begin
              r_state <= ST_NEWBALL;
              r_timer <= SERVE_V;
            end
          end
        end
        ST_NEWBALL: begin
          r_gra_still <= 1'b1;
          if (r_timer != 8'd0) begin
            if (i_frame_tick) r_timer <= r_timer - 8'd1;
          end else if (w_press) begin
            r_state     <= ST_PLAY;
            r_gra_still <= 1'b0;
          end
        end
        ST_OVER: begin
          r_gra_still <= 1'b1;
          if (r_timer == 8'd0) begin
            // enter NEWGAME with its outputs already valid
            r_state  <= ST_NEWGAME;
            r_d1_clr <= 1'b1;
            r_d2_clr <= 1'b1;
            r_ball   <= BALLS_V;
            r_s1     <= 7'd0;
            r_s2     <= 7'd0;
            r_winner <= 2'b00;
          end else if (i_frame_tick) begin
            r_timer <= r_timer - 8'd1;
          end
        end
        default: r_state <= ST_NEWGAME;
      endcase
    end
  end

  assign o_gra_still  = r_gra_still;
  assign o_d1_inc     = r_d1_inc;
  assign o_d1_clr     = r_d1_clr;
  assign o_d2_inc     = r_d2_inc;
  assign o_d2_clr     = r_d2_clr;
  assign o_ball       = r_ball;
  assign o_state      = r_state;
  assign o_serve_side = r_serve_side;
  assign o_winner     = r_winner;

endmodule
